uart_tx_queue: RTL and testbench

Buffered UART transmit path between the CPU core and the AXI4-lite UART Lite peripheral. The core pushes bytes with a valid/ready handshake into an internal FIFO. The block drains the FIFO on its own: for each byte it polls STAT_REG until the Tx FIFO Full flag is clear, then writes the byte to TX_FIFO. This takes the per-byte status polling out of the core's OUT instruction handling.

---
 rtl/uart_tx_queue_if.sv | 43 ++++
 rtl/uart_tx_queue.sv | 154 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Bundle of the core-side byte push port and the AXI4-lite master port of uart_tx_queue.
// The master modport is the queue's view; the slave modport is the core/UART side.
interface uart_tx_queue_if #(
    parameter int unsigned DEPTH = 16
);
    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [$clog2(DEPTH):0]  level;
    logic                    busy;
    logic                    err;

    logic [3:0]              araddr;
    logic                    arvalid;
    logic                    arready;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    logic [3:0]              awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        input  in_data, in_valid, arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        output in_ready, level, busy, err, araddr, arvalid, rready, awaddr, awvalid, wdata,
               wstrb, wvalid, bready
    );

    modport slave (
        output in_data, in_valid, arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        input  in_ready, level, busy, err, araddr, arvalid, rready, awaddr, awvalid, wdata,
               wstrb, wvalid, bready
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of the AXI4-lite UART Lite: polls STAT_REG until the Tx FIFO has room,
// then writes the head byte to TX_FIFO, one outstanding transaction at a time.
module uart_tx_queue #(
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_queue_if.master  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [2:0] {StIdle, StAr, StR, StW, StB} state_e;

    state_e          state_q;
    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [LW-1:0]   level_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            awvalid_q;
    logic            wvalid_q;
    logic            bready_q;
    logic            err_q;
    logic [7:0]      wbyte_q;
    logic            in_ready;
    logic            push;
    logic            pop;
    logic            aw_done;
    logic            w_done;
    logic            unused_rdata;

    // Only the Tx FIFO Full flag of STAT_REG matters here.
    assign unused_rdata = ^{bus.rdata[31:4], bus.rdata[2:0]};

    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = bus.in_valid && in_ready;
    assign pop      = (state_q == StB) && bus.bvalid;

    assign bus.in_ready = in_ready;
    assign bus.level    = level_q;
    assign bus.busy     = (level_q != '0) || (state_q != StIdle);
    assign bus.err      = err_q;
    assign bus.araddr   = 4'h8;
    assign bus.arvalid  = arvalid_q;
    assign bus.rready   = rready_q;
    assign bus.awaddr   = 4'h4;
    assign bus.awvalid  = awvalid_q;
    assign bus.wdata    = {24'h0, wbyte_q};
    assign bus.wstrb    = 4'b0001;
    assign bus.wvalid   = wvalid_q;
    assign bus.bready   = bready_q;

    // A channel counts as done once its valid has dropped or its handshake is on this edge.
    assign aw_done = !awvalid_q || bus.awready;
    assign w_done  = !wvalid_q || bus.wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (!push && pop) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            err_q     <= 1'b0;
            wbyte_q   <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (level_q != '0) begin
                        arvalid_q <= 1'b1;
                        state_q   <= StAr;
                    end
                end
                StAr: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StR;
                    end
                end
                StR: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        if (bus.rresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (bus.rdata[3]) begin
                            arvalid_q <= 1'b1;
                            state_q   <= StAr;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            wbyte_q   <= mem_q[rd_ptr_q];
                            state_q   <= StW;
                        end
                    end
                end
                StW: begin
                    if (bus.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (bus.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= StB;
                    end
                end
                StB: begin
                    if (bus.bvalid) begin
                        bready_q <= 1'b0;
                        if (bus.bresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: reactive AXI4-lite slave model with a wdata scoreboard plus directed
// timing, back-pressure, FIFO-full, split-handshake, error and reset scenarios.
module tb_uart_tx_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_queue_if #(.DEPTH(16)) bus ();

    uart_tx_queue #(.DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [$];

    // Slave knobs, written only by the stimulus process.
    int   ar_dly = 0;
    int   aw_dly = 0;
    int   w_dly = 0;
    logic w_hold = 1'b0;
    int   stat_full_end = 0;
    int   rresp_err_idx = -1;
    int   bresp_err_idx = -1;

    // Slave state, written only by the slave process.
    int   ar_count = 0;
    int   aw_count = 0;
    int   r_count = 0;
    int   b_count = 0;
    int   ar_wait = 0;
    int   aw_wait = 0;
    int   w_wait = 0;
    logic ar_fire = 0, r_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0;
    logic r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        if (bus.in_ready) sb.push_back(b);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && (bus.busy || bus.level != 0); i++) tick();
        check("idle timeout busy", {31'h0, bus.busy}, 32'h0);
    endtask

    // Slave acts on the falling edge; fire flags carry handshakes seen at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            bus.rdata = 0; bus.rresp = 0; bus.bresp = 0;
            ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            ar_wait = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (r_pend) begin
                bus.rvalid = 1;
                bus.rdata  = (r_count < stat_full_end) ? 32'h8 : 32'h0;
                bus.rresp  = (r_count == rresp_err_idx) ? 2'b10 : 2'b00;
                r_count++;
                r_pend = 0;
            end
            if (b_pend) begin
                bus.bvalid = 1;
                bus.bresp  = (b_count == bresp_err_idx) ? 2'b10 : 2'b00;
                b_count++;
                b_pend = 0;
            end
            if (ar_fire) begin
                ar_count++;
                check("araddr", {28'h0, bus.araddr}, 32'h8);
                r_pend = 1;
            end
            if (r_fire) bus.rvalid = 0;
            if (aw_fire) begin
                aw_count++;
                check("awaddr", {28'h0, bus.awaddr}, 32'h4);
                aw_got = 1;
            end
            if (w_fire) begin
                logic [7:0] exp_b;
                check("wstrb", {28'h0, bus.wstrb}, 32'h1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wdata: got unexpected 0x%0h, expected no write", bus.wdata);
                end else begin
                    exp_b = sb.pop_front();
                    check("wdata", bus.wdata, {24'h0, exp_b});
                end
                w_got = 1;
            end
            if (b_fire) bus.bvalid = 0;
            if (aw_got && w_got) begin
                b_pend = 1;
                aw_got = 0;
                w_got  = 0;
            end
            ar_wait = bus.arvalid ? ar_wait + 1 : 0;
            aw_wait = bus.awvalid ? aw_wait + 1 : 0;
            w_wait  = bus.wvalid ? w_wait + 1 : 0;
            bus.arready = bus.arvalid && (ar_wait > ar_dly);
            bus.awready = bus.awvalid && (aw_wait > aw_dly);
            bus.wready  = bus.wvalid && !w_hold && (w_wait > w_dly);
            ar_fire = bus.arvalid && bus.arready;
            r_fire  = bus.rvalid && bus.rready;
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            b_fire  = bus.bvalid && bus.bready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ar0;
        int aw0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst arvalid", {31'h0, bus.arvalid}, 32'h0);
        check("rst rready", {31'h0, bus.rready}, 32'h0);
        check("rst awvalid", {31'h0, bus.awvalid}, 32'h0);
        check("rst wvalid", {31'h0, bus.wvalid}, 32'h0);
        check("rst bready", {31'h0, bus.bready}, 32'h0);
        check("rst err", {31'h0, bus.err}, 32'h0);
        check("rst wdata", bus.wdata, 32'h0);
        check("rst level", {27'h0, bus.level}, 32'h0);
        check("rst in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("rst busy", {31'h0, bus.busy}, 32'h0);
        check("araddr const", {28'h0, bus.araddr}, 32'h8);
        check("awaddr const", {28'h0, bus.awaddr}, 32'h4);
        check("wstrb const", {28'h0, bus.wstrb}, 32'h1);
        rst = 1'b0;
        tick();

        // Single byte, zero-wait slave; after push_byte returns we sit 3 ns past edge k.
        push_byte(8'h5A);
        check("k level", {27'h0, bus.level}, 32'h1);
        check("k arvalid", {31'h0, bus.arvalid}, 32'h0);
        tick();
        check("k+1 arvalid", {31'h0, bus.arvalid}, 32'h1);
        tick();
        check("k+2 rready", {31'h0, bus.rready}, 32'h1);
        tick();
        tick();
        check("k+4 awvalid", {31'h0, bus.awvalid}, 32'h1);
        check("k+4 wvalid", {31'h0, bus.wvalid}, 32'h1);
        check("k+4 wdata", bus.wdata, 32'h5A);
        tick();
        check("k+5 bready", {31'h0, bus.bready}, 32'h1);
        tick();
        check("k+6 level", {27'h0, bus.level}, 32'h1);
        tick();
        check("k+7 level", {27'h0, bus.level}, 32'h0);
        tick();
        check("k+8 busy", {31'h0, bus.busy}, 32'h0);
        check("k+8 arvalid", {31'h0, bus.arvalid}, 32'h0);

        // Tx FIFO full reported three times before room appears.
        ar0 = ar_count;
        aw0 = aw_count;
        stat_full_end = r_count + 3;
        push_byte(8'h33);
        wait_idle();
        check("poll ar count", ar_count - ar0, 32'd4);
        check("poll aw count", aw_count - aw0, 32'd1);

        // awready late, wready immediate.
        aw_dly = 5;
        push_byte(8'hC3);
        for (int i = 0; i < 50 && !bus.wvalid; i++) tick();
        check("split1 wvalid up", {31'h0, bus.wvalid}, 32'h1);
        tick();
        check("split1 wvalid down", {31'h0, bus.wvalid}, 32'h0);
        check("split1 awvalid held", {31'h0, bus.awvalid}, 32'h1);
        check("split1 bready early", {31'h0, bus.bready}, 32'h0);
        for (int i = 0; i < 50 && bus.awvalid; i++) tick();
        check("split1 bready", {31'h0, bus.bready}, 32'h1);
        wait_idle();
        aw_dly = 0;

        // wready late, awready immediate.
        w_dly = 5;
        push_byte(8'h3C);
        for (int i = 0; i < 50 && !bus.awvalid; i++) tick();
        check("split2 awvalid up", {31'h0, bus.awvalid}, 32'h1);
        tick();
        check("split2 awvalid down", {31'h0, bus.awvalid}, 32'h0);
        check("split2 wvalid held", {31'h0, bus.wvalid}, 32'h1);
        check("split2 wdata held", bus.wdata, 32'h3C);
        check("split2 bready early", {31'h0, bus.bready}, 32'h0);
        for (int i = 0; i < 50 && bus.wvalid; i++) tick();
        check("split2 bready", {31'h0, bus.bready}, 32'h1);
        wait_idle();
        w_dly = 0;

        // Fill the FIFO while the write data channel is stalled.
        w_hold = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("full level", {27'h0, bus.level}, 32'd16);
        check("full in_ready", {31'h0, bus.in_ready}, 32'h0);
        push_byte(8'hEE);
        check("full level after 17th", {27'h0, bus.level}, 32'd16);
        check("full wdata head", bus.wdata, 32'h0);
        w_hold = 1'b0;
        wait_idle();
        check("full drained level", {27'h0, bus.level}, 32'h0);
        check("full scoreboard empty", sb.size(), 32'h0);

        // Write response error on the first of two bytes.
        bresp_err_idx = b_count;
        push_byte(8'hA1);
        push_byte(8'hA2);
        wait_idle();
        check("bresp err", {31'h0, bus.err}, 32'h1);
        check("bresp both popped", sb.size(), 32'h0);

        // Reset while the write phase is in flight, with err still set.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        for (int i = 0; i < 50 && !bus.awvalid; i++) tick();
        check("midw awvalid up", {31'h0, bus.awvalid}, 32'h1);
        rst = 1'b1;
        #1;
        check("midw awvalid", {31'h0, bus.awvalid}, 32'h0);
        check("midw wvalid", {31'h0, bus.wvalid}, 32'h0);
        check("midw level", {27'h0, bus.level}, 32'h0);
        check("midw in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("midw err", {31'h0, bus.err}, 32'h0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        ar0 = ar_count;
        aw0 = aw_count;
        for (int i = 0; i < 20; i++) tick();
        check("post reset ar count", ar_count - ar0, 32'h0);
        check("post reset aw count", aw_count - aw0, 32'h0);
        check("post reset busy", {31'h0, bus.busy}, 32'h0);

        // Read response error.
        rresp_err_idx = r_count;
        push_byte(8'h77);
        wait_idle();
        check("rresp err", {31'h0, bus.err}, 32'h1);
        check("rresp scoreboard empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
